// File: rtl/avmm_user_fifo_bank.sv
// avmm_user_fifo_bank: N user-push FIFOs drained through one Avalon-MM slave.
// Define AVMM_FIFO_BANK_IRQ_EN to add the irq port and the CTRL irq_en bit.
module avmm_user_fifo_bank #(
    parameter  int CHANNELS   = 2,
    parameter  int DATA_W     = 32,
    parameter  int DEPTH_LOG2 = 6,
    localparam int ADDR_W     = $clog2(CHANNELS) + 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [ADDR_W-1:0]          avs_address,
    input  logic                       avs_read,
    input  logic                       avs_write,
    input  logic [31:0]                avs_writedata,
    output logic [31:0]                avs_readdata,
    input  logic [CHANNELS-1:0]        user_wrreq,
    input  logic [CHANNELS*DATA_W-1:0] user_data,
    output logic [CHANNELS-1:0]        user_flag_0,
    output logic [CHANNELS-1:0]        user_flag_1
`ifdef AVMM_FIFO_BANK_IRQ_EN
    ,
    output logic                       irq
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LW    = DEPTH_LOG2 + 1;

    logic [ADDR_W-1:0]          ch_idx;
    logic [1:0]                 reg_sel;
    logic [CHANNELS-1:0][31:0]  rd_word;
    logic [CHANNELS-1:0]        irqen_v;
    logic [31:0]                rd_mux;
    logic [31:0]                rdata_q;
    logic                       unused_wdata;

    assign ch_idx       = avs_address >> 2;
    assign reg_sel      = avs_address[1:0];
    assign unused_wdata = ^avs_writedata;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [DATA_W-1:0]     mem [DEPTH];
        logic [DEPTH_LOG2-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
        logic [LW-1:0]         level_q, level_d, thresh_q, thresh_d;
        logic                  ovf_q, ovf_d, flag_q, flag_d;
        logic                  sel, wr_go, empty, full, pop, flush, push_ok;
        logic                  irqen;
        logic [31:0]           rdw;

        assign sel     = (ch_idx == ADDR_W'(c));
        assign wr_go   = avs_write & sel;
        assign empty   = (level_q == '0);
        assign full    = (level_q == LW'(DEPTH));
        assign pop     = avs_read & sel & (reg_sel == 2'd0) & ~empty;
        assign flush   = wr_go & (reg_sel == 2'd3) & avs_writedata[0];
        // A pop in the same cycle frees the slot a full FIFO needs.
        assign push_ok = user_wrreq[c] & ~flush & (~full | pop);

        always_comb begin
            wptr_d   = wptr_q;
            rptr_d   = rptr_q;
            level_d  = level_q;
            thresh_d = thresh_q;
            ovf_d    = ovf_q;
            if (wr_go && reg_sel == 2'd1 && avs_writedata[18]) ovf_d = 1'b0;
            if (user_wrreq[c] && !flush && full && !pop) ovf_d = 1'b1;
            if (wr_go && reg_sel == 2'd2) thresh_d = avs_writedata[LW-1:0];
            if (flush) begin
                wptr_d  = '0;
                rptr_d  = '0;
                level_d = '0;
            end else begin
                wptr_d  = wptr_q + DEPTH_LOG2'(push_ok);
                rptr_d  = rptr_q + DEPTH_LOG2'(pop);
                level_d = level_q + LW'(push_ok) - LW'(pop);
            end
            flag_d = (level_d >= thresh_d);
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                wptr_q   <= '0;
                rptr_q   <= '0;
                level_q  <= '0;
                thresh_q <= LW'(DEPTH / 2);
                ovf_q    <= 1'b0;
                flag_q   <= 1'b0;
            end else begin
                wptr_q   <= wptr_d;
                rptr_q   <= rptr_d;
                level_q  <= level_d;
                thresh_q <= thresh_d;
                ovf_q    <= ovf_d;
                flag_q   <= flag_d;
            end
        end

        always_ff @(posedge clk) begin
            if (push_ok) mem[wptr_q] <= user_data[c*DATA_W +: DATA_W];
        end

`ifdef AVMM_FIFO_BANK_IRQ_EN
        logic irqen_q;
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                irqen_q <= 1'b0;
            end else if (wr_go && reg_sel == 2'd3) begin
                irqen_q <= avs_writedata[1];
            end
        end
        assign irqen = irqen_q;
`else
        assign irqen = 1'b0;
`endif

        always_comb begin
            rdw = '0;
            unique case (reg_sel)
                2'd0: rdw = empty ? '0 : 32'(mem[rptr_q]);
                2'd1: begin
                    rdw[LW-1:0] = level_q;
                    rdw[16]     = empty;
                    rdw[17]     = full;
                    rdw[18]     = ovf_q;
                end
                2'd2: rdw[LW-1:0] = thresh_q;
                default: rdw[1] = irqen;
            endcase
        end

        assign rd_word[c]     = rdw & {32{sel}};
        assign irqen_v[c]     = irqen;
        assign user_flag_0[c] = flag_q;
        assign user_flag_1[c] = ovf_q;
    end

    always_comb begin
        rd_mux = '0;
        for (int c = 0; c < CHANNELS; c++) rd_mux |= rd_word[c];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= '0;
        end else if (avs_read) begin
            rdata_q <= rd_mux;
        end
    end

    assign avs_readdata = rdata_q;

`ifdef AVMM_FIFO_BANK_IRQ_EN
    logic irq_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |(irqen_v & (user_flag_0 | user_flag_1));
        end
    end
    assign irq = irq_q;
`else
    logic unused_irqen;
    assign unused_irqen = ^irqen_v;
`endif

endmodule

// File: tb/tb_avmm_user_fifo_bank.sv
// Scoreboard bench for avmm_user_fifo_bank (2 channels, 32-bit, depth 64).
// Reads queue their expected word; a monitor compares readdata one cycle later.
module tb_avmm_user_fifo_bank;

    localparam int AW = 3;

    typedef struct {
        logic [31:0] v;
        string       n;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [AW-1:0] avs_address = '0;
    logic          avs_read = 1'b0;
    logic          avs_write = 1'b0;
    logic [31:0]   avs_writedata = '0;
    logic [31:0]   avs_readdata;
    logic [1:0]    user_wrreq = '0;
    logic [63:0]   user_data = '0;
    logic [1:0]    user_flag_0;
    logic [1:0]    user_flag_1;
`ifdef AVMM_FIFO_BANK_IRQ_EN
    logic          irq;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t e;

    avmm_user_fifo_bank dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .avs_address  (avs_address),
        .avs_read     (avs_read),
        .avs_write    (avs_write),
        .avs_writedata(avs_writedata),
        .avs_readdata (avs_readdata),
        .user_wrreq   (user_wrreq),
        .user_data    (user_data),
        .user_flag_0  (user_flag_0),
        .user_flag_1  (user_flag_1)
`ifdef AVMM_FIFO_BANK_IRQ_EN
        ,
        .irq          (irq)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    always @(posedge clk) begin
        if (avs_read) begin
            #1;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected got %h", avs_readdata);
            end else begin
                e = sb.pop_front();
                if (avs_readdata !== e.v) begin
                    errors++;
                    $display("FAIL %s got %h exp %h", e.n, avs_readdata, e.v);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", nm, act, exp);
        end
    endtask

    task automatic rd(input int ch, input int r, input logic [31:0] exp,
                      input string nm);
        avs_address = AW'(ch * 4 + r);
        avs_read    = 1'b1;
        sb.push_back('{v: exp, n: nm});
        @(negedge clk);
        avs_read = 1'b0;
    endtask

    task automatic wr(input int ch, input int r, input logic [31:0] d);
        avs_address   = AW'(ch * 4 + r);
        avs_writedata = d;
        avs_write     = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
    endtask

    task automatic push(input int ch, input logic [31:0] d);
        user_wrreq[ch]        = 1'b1;
        user_data[ch*32 +: 32] = d;
        @(negedge clk);
        user_wrreq = '0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_rdata", avs_readdata, 0);
        chk("rst_flag0", 32'(user_flag_0), 0);
        chk("rst_flag1", 32'(user_flag_1), 0);
        reset_n = 1'b1;
        @(negedge clk);
        rd(0, 1, 32'h10000, "rst_status0");
        rd(1, 1, 32'h10000, "rst_status1");
        rd(0, 2, 32, "rst_thresh0");
        rd(0, 3, 0, "rst_ctrl0");

        for (int i = 0; i < 31; i++) push(0, 32'(100 + i));
        chk("flag0_at31", 32'(user_flag_0), 0);
        push(0, 131);
        chk("flag0_at32", 32'(user_flag_0), 32'b01);
        rd(0, 1, 32'h20, "status0_32");

        for (int i = 0; i < 64; i++) push(1, 32'(i));
        chk("flag1_full", 32'(user_flag_1), 0);
        push(1, 99);
        chk("flag1_ovf", 32'(user_flag_1), 32'b10);
        chk("flag0_both", 32'(user_flag_0), 32'b11);
        rd(1, 1, 32'h60040, "status1_ovf");
        for (int i = 0; i < 64; i++) rd(1, 0, 32'(i), "drain1");
        rd(1, 0, 0, "empty_read1");
        rd(1, 1, 32'h50000, "status1_empty");
        wr(1, 1, 32'h40000);
        chk("flag1_clr", 32'(user_flag_1), 0);
        rd(1, 1, 32'h10000, "status1_clr");

        for (int i = 32; i < 64; i++) push(0, 32'(100 + i));
        rd(0, 1, 32'h20040, "status0_full");
        avs_address       = AW'(0);
        avs_read          = 1'b1;
        user_wrreq[0]     = 1'b1;
        user_data[31:0]   = 32'hAA;
        sb.push_back('{v: 32'd100, n: "pushpop_head"});
        @(negedge clk);
        avs_read   = 1'b0;
        user_wrreq = '0;
        rd(0, 1, 32'h20040, "status0_pushpop");
        chk("flag1_pushpop", 32'(user_flag_1), 0);
        for (int i = 1; i < 64; i++) rd(0, 0, 32'(100 + i), "drain0");
        rd(0, 0, 32'hAA, "drain0_last");
        rd(0, 1, 32'h10000, "status0_drained");

        wr(0, 2, 5);
        for (int i = 0; i < 20; i++) push(0, 32'(200 + i));
        rd(0, 1, 32'h14, "status0_20");
        chk("flag0_20", 32'(user_flag_0), 32'b01);
        user_wrreq[0]   = 1'b1;
        user_data[31:0] = 32'hDEAD;
        wr(0, 3, 1);
        user_wrreq = '0;
        rd(0, 1, 32'h10000, "status0_flush");
        chk("flag0_flush", 32'(user_flag_0), 0);
        chk("flag1_flush", 32'(user_flag_1), 0);
        push(0, 32'h77);
        rd(0, 0, 32'h77, "after_flush_data");
        rd(0, 1, 32'h10000, "after_flush_status");
        rd(0, 2, 5, "thresh_kept");
        rd(0, 3, 0, "ctrl_flush_clear");

        wr(1, 2, 0);
        chk("thresh0_forces", 32'(user_flag_0), 32'b10);
        wr(1, 2, 127);
        chk("thresh_over", 32'(user_flag_0), 0);

        rd(0, 2, 5, "thresh0_prereset");
        for (int i = 0; i < 10; i++) push(0, 32'(300 + i));
        chk("flag0_prereset", 32'(user_flag_0), 32'b01);
        user_wrreq[0] = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        chk("async_rdata", avs_readdata, 0);
        chk("async_flag0", 32'(user_flag_0), 0);
        chk("async_flag1", 32'(user_flag_1), 0);
        @(negedge clk);
        user_wrreq = '0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        rd(0, 1, 32'h10000, "post_rst_status0");
        rd(0, 2, 32, "post_rst_thresh0");
        rd(1, 2, 32, "post_rst_thresh1");

`ifdef AVMM_FIFO_BANK_IRQ_EN
        wr(0, 3, 2);
        wr(0, 2, 1);
        rd(0, 3, 2, "ctrl_irqen");
        chk("irq_idle", 32'(irq), 0);
        push(0, 32'h55);
        chk("irq_flag", 32'(user_flag_0), 32'b01);
        chk("irq_cycle1", 32'(irq), 0);
        @(negedge clk);
        chk("irq_cycle2", 32'(irq), 1);
        wr(0, 3, 0);
        @(negedge clk);
        chk("irq_cleared", 32'(irq), 0);
`else
        wr(0, 3, 2);
        rd(0, 3, 0, "ctrl_no_irqen");
`endif

        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got %0d exp 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
